// File: rtl/ora_misr.sv
// Output response analyzer: compacts CUT responses in a MISR, grades each session against a
// golden signature and pattern count, and pulses ORA_RES once per evaluated session.
module ora_misr #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] POLY     = 'h1D,
   parameter logic [WIDTH-1:0] SEED     = '0,
   parameter logic [WIDTH-1:0] GOLDEN   = '0,
   parameter int               PATTERNS = 255,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             RESET_N,
   input  logic             TPG_RESET,
   input  logic [WIDTH-1:0] CUT_OUT,
   input  logic             CUT_VALID,
   input  logic             TPG_END,
   output logic             ORA_RES,
   output logic             PASS,
   output logic             FAIL,
   output logic             FAIL_ANY,
   output logic [WIDTH-1:0] SIGNATURE,
   output logic [CNT_W-1:0] PAT_CNT,
   output logic [7:0]       SESS_CNT
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_COMPACT = 2'd1;
   localparam logic [1:0] ST_REPORT  = 2'd2;
   localparam logic [1:0] ST_CLEAR   = 2'd3;

   localparam logic [CNT_W-1:0] PAT_EXP = CNT_W'(PATTERNS);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sig;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pass;
   logic             r_fail;
   logic             r_fail_any;
   logic [7:0]       r_sess;

   logic [WIDTH-1:0] w_sig_step;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [WIDTH-1:0] w_sig_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_pass;

   // Feedback uses the MSB before the shift; the response is folded in after the taps.
   assign w_sig_step = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ CUT_OUT;
   assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_sig_nxt  = CUT_VALID ? w_sig_step : r_sig;
   assign w_cnt_nxt  = CUT_VALID ? w_cnt_inc  : r_cnt;

   // Grading sees the vector arriving alongside TPG_END.
   assign w_pass = (w_sig_nxt == GOLDEN) && (w_cnt_nxt == PAT_EXP);

   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state    <= ST_IDLE;
         r_sig      <= SEED;
         r_cnt      <= '0;
         r_pass     <= 1'b0;
         r_fail     <= 1'b0;
         r_fail_any <= 1'b0;
         r_sess     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (TPG_RESET) begin
                  r_sig <= SEED;
                  r_cnt <= '0;
               end else begin
                  r_state <= ST_COMPACT;
                  r_sig   <= w_sig_nxt;
                  r_cnt   <= w_cnt_nxt;
               end
            end
            ST_COMPACT: begin
               if (TPG_RESET) begin
                  r_state <= ST_IDLE;
                  r_sig   <= SEED;
                  r_cnt   <= '0;
               end else begin
                  r_sig <= w_sig_nxt;
                  r_cnt <= w_cnt_nxt;
                  if (TPG_END) begin
                     r_state    <= ST_REPORT;
                     r_pass     <= w_pass;
                     r_fail     <= !w_pass;
                     r_fail_any <= r_fail_any | !w_pass;
                  end
               end
            end
            ST_REPORT: begin
               r_state <= ST_CLEAR;
               r_sess  <= r_sess + 8'd1;
            end
            ST_CLEAR: begin
               if (TPG_RESET) begin
                  r_state <= ST_IDLE;
                  r_sig   <= SEED;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ORA_RES   = (r_state == ST_REPORT);
   assign PASS      = r_pass;
   assign FAIL      = r_fail;
   assign FAIL_ANY  = r_fail_any;
   assign SIGNATURE = r_sig;
   assign PAT_CNT   = r_cnt;
   assign SESS_CNT  = r_sess;

endmodule

// File: tb/tb_ora_misr.sv
// Directed bench for ora_misr: table of per-cycle vectors plus hand sequences for the
// held-TPG_END, SEED feedback, counter saturation and asynchronous reset cases.
module tb_ora_misr;

   logic       clk = 1'b0;
   logic       RESET_N;
   logic       TPG_RESET;
   logic [3:0] CUT_OUT;
   logic       CUT_VALID;
   logic       TPG_END;

   logic       ora, pass, fail, fail_any;
   logic [3:0] sig, cnt;
   logic [7:0] sess;
   logic       ora2, pass2, fail2, fail_any2;
   logic [3:0] sig2, cnt2;
   logic [7:0] sess2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ora_misr #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'h3), .PATTERNS(3), .CNT_W(4)) dut (
      .clk(clk), .RESET_N(RESET_N), .TPG_RESET(TPG_RESET), .CUT_OUT(CUT_OUT),
      .CUT_VALID(CUT_VALID), .TPG_END(TPG_END), .ORA_RES(ora), .PASS(pass), .FAIL(fail),
      .FAIL_ANY(fail_any), .SIGNATURE(sig), .PAT_CNT(cnt), .SESS_CNT(sess));

   // Same control stream, different seed: only its signature is graded.
   ora_misr #(.WIDTH(4), .POLY(4'h3), .SEED(4'h8), .GOLDEN(4'h3), .PATTERNS(3), .CNT_W(4)) dut_seed (
      .clk(clk), .RESET_N(RESET_N), .TPG_RESET(TPG_RESET), .CUT_OUT(CUT_OUT),
      .CUT_VALID(CUT_VALID), .TPG_END(TPG_END), .ORA_RES(ora2), .PASS(pass2), .FAIL(fail2),
      .FAIL_ANY(fail_any2), .SIGNATURE(sig2), .PAT_CNT(cnt2), .SESS_CNT(sess2));

   typedef struct {
      logic       v;
      logic [3:0] c;
      logic       e;
      logic       r;
      logic [3:0] sig;
      logic [3:0] cnt;
      logic       ora;
      logic       pass;
      logic       fail;
      logic       fa;
      logic [7:0] sess;
   } vec_t;

   vec_t tbl[$];

   task automatic row(input logic v, input logic [3:0] c, input logic e, input logic r,
                      input logic [3:0] s, input logic [3:0] n, input logic o, input logic p,
                      input logic f, input logic fa, input logic [7:0] ss);
      vec_t t;
      t.v = v; t.c = c; t.e = e; t.r = r; t.sig = s; t.cnt = n;
      t.ora = o; t.pass = p; t.fail = f; t.fa = fa; t.sess = ss;
      tbl.push_back(t);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic e, input logic r);
      CUT_VALID = v; CUT_OUT = c; TPG_END = e; TPG_RESET = r;
   endtask

   int ora_seen, ora2_seen;

   initial begin
      RESET_N = 1'b0;
      drive(1'b0, 4'h0, 1'b0, 1'b1);

      // Row fields: valid, cut, end, tpg_reset -> sig, cnt, ora, pass, fail, fail_any, sess
      // Session 1,2,3 -> pass
      row(1,1,0,0, 1,1,0, 0,0,0,0); row(1,2,0,0, 0,2,0, 0,0,0,0);
      row(1,3,0,0, 3,3,0, 0,0,0,0); row(0,0,1,0, 3,3,1, 1,0,0,0);
      row(0,0,0,0, 3,3,0, 1,0,0,1); row(0,0,0,1, 0,0,0, 1,0,0,1);
      row(0,0,0,0, 0,0,0, 1,0,0,1);
      // Session 1,2,2 -> fail, sticky set
      row(1,1,0,0, 1,1,0, 1,0,0,1); row(1,2,0,0, 0,2,0, 1,0,0,1);
      row(1,2,0,0, 2,3,0, 1,0,0,1); row(0,0,1,0, 2,3,1, 0,1,1,1);
      row(0,0,0,0, 2,3,0, 0,1,1,2); row(0,0,0,1, 0,0,0, 0,1,1,2);
      row(0,0,0,0, 0,0,0, 0,1,1,2);
      // Passing session after a failure: FAIL_ANY stays
      row(1,1,0,0, 1,1,0, 0,1,1,2); row(1,2,0,0, 0,2,0, 0,1,1,2);
      row(1,3,0,0, 3,3,0, 0,1,1,2); row(0,0,1,0, 3,3,1, 1,0,1,2);
      row(0,0,0,0, 3,3,0, 1,0,1,3); row(0,0,0,1, 0,0,0, 1,0,1,3);
      row(0,0,0,0, 0,0,0, 1,0,1,3);
      // Empty session: TPG_END on first COMPACT cycle
      row(0,0,1,0, 0,0,1, 0,1,1,3); row(0,0,0,0, 0,0,0, 0,1,1,4);
      row(0,0,0,1, 0,0,0, 0,1,1,4); row(0,0,0,0, 0,0,0, 0,1,1,4);
      // Last vector together with TPG_END
      row(1,1,0,0, 1,1,0, 0,1,1,4); row(1,2,0,0, 0,2,0, 0,1,1,4);
      row(1,3,1,0, 3,3,1, 1,0,1,4); row(0,0,0,0, 3,3,0, 1,0,1,5);
      row(0,0,0,1, 0,0,0, 1,0,1,5); row(0,0,0,0, 0,0,0, 1,0,1,5);
      // TPG_RESET beats TPG_END; IDLE ignores CUT_VALID under TPG_RESET
      row(1,1,0,0, 1,1,0, 1,0,1,5); row(1,2,1,1, 0,0,0, 1,0,1,5);
      row(1,5,0,1, 0,0,0, 1,0,1,5); row(0,0,0,0, 0,0,0, 1,0,1,5);
      // Abort after two vectors, then a clean passing session
      row(1,1,0,0, 1,1,0, 1,0,1,5); row(1,2,0,0, 0,2,0, 1,0,1,5);
      row(0,0,0,1, 0,0,0, 1,0,1,5); row(0,0,0,0, 0,0,0, 1,0,1,5);
      row(1,1,0,0, 1,1,0, 1,0,1,5); row(1,2,0,0, 0,2,0, 1,0,1,5);
      row(1,3,0,0, 3,3,0, 1,0,1,5); row(0,0,1,0, 3,3,1, 1,0,1,5);
      row(0,0,0,0, 3,3,0, 1,0,1,6); row(0,0,0,1, 0,0,0, 1,0,1,6);
      row(0,0,0,0, 0,0,0, 1,0,1,6);

      repeat (3) tick();
      check("reset_sig", sig, 0);
      check("reset_cnt", cnt, 0);
      check("reset_ora", ora, 0);
      check("reset_flags", {pass, fail, fail_any}, 0);
      check("reset_sess", sess, 0);
      check("reset_seed_sig", sig2, 8);

      RESET_N = 1'b1;
      tick();                                  // IDLE held by TPG_RESET
      check("idle_hold_sig", sig, 0);
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      tick();                                  // IDLE -> COMPACT

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].r);
         tick();
         check($sformatf("row%0d_sig", i), sig, tbl[i].sig);
         check($sformatf("row%0d_cnt", i), cnt, tbl[i].cnt);
         check($sformatf("row%0d_ora", i), ora, tbl[i].ora);
         check($sformatf("row%0d_pass", i), pass, tbl[i].pass);
         check($sformatf("row%0d_fail", i), fail, tbl[i].fail);
         check($sformatf("row%0d_failany", i), fail_any, tbl[i].fa);
         check($sformatf("row%0d_sess", i), sess, tbl[i].sess);
      end

      // SEED=8 with vector 0: MSB feedback gives 3
      drive(1'b1, 4'h0, 1'b0, 1'b0);
      tick();
      check("seed_fb_sig", sig2, 3);
      check("seed0_sig", sig, 0);

      // TPG_END held 5 cycles; CUT_VALID noise in REPORT/CLEAR must not compact
      ora_seen = 0; ora2_seen = 0;
      for (int k = 0; k < 5; k++) begin
         drive(k != 0, 4'h5, 1'b1, 1'b0);
         tick();
         ora_seen  += int'(ora);
         ora2_seen += int'(ora2);
      end
      check("held_end_ora", ora_seen, 1);
      check("held_end_ora_seed", ora2_seen, 1);
      check("held_end_sig", sig, 0);
      check("held_end_cnt", cnt, 1);
      check("held_end_seed_sig", sig2, 3);
      check("held_end_sess", sess, 7);
      check("held_end_fail", fail, 1);
      drive(1'b0, 4'h0, 1'b0, 1'b1);
      tick();
      check("clear_seed_sig", sig2, 8);
      drive(1'b0, 4'h0, 1'b0, 1'b0);
      tick();

      // PAT_CNT saturates at all-ones
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 4'h0, 1'b0, 1'b0);
         tick();
         if (k == 14) check("cnt_reach_max", cnt, 15);
      end
      check("cnt_saturated", cnt, 15);

      // Mid-session async reset: no clock edge before checking
      drive(1'b1, 4'h1, 1'b0, 1'b0);
      tick();
      check("pre_reset_failany", fail_any, 1);
      RESET_N = 1'b0;
      #2;
      check("async_sig", sig, 0);
      check("async_cnt", cnt, 0);
      check("async_flags", {ora, pass, fail, fail_any}, 0);
      check("async_sess", sess, 0);
      check("async_seed_sig", sig2, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
